// File: rtl/popcount_seq_ctrl.sv
// Byte-serial population count sequencer driving one external 8-bit count_ones unit.
// Optional feature: define PARITY_EN to add the out_parity output.
module popcount_seq_ctrl #(
    parameter int NBYTES = 4,
    localparam int SUM_W = $clog2(8 * NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    output logic [7:0]            cu_byte,
    input  logic [3:0]            cu_ones,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_W-1:0]      out_count,
    output logic                  busy
`ifdef PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam int IDX_W = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [8*NBYTES-1:0]   shreg;
    logic [SUM_W-1:0]      acc;
    logic [SUM_W-1:0]      acc_next;
    logic [IDX_W-1:0]      idx;
    logic                  last_byte;

    assign acc_next  = acc + SUM_W'(cu_ones);
    assign last_byte = (idx == IDX_W'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // in_ready comes from state alone, so DONE->IDLE never overlaps an accept.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        cu_byte    = 8'h00;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                cu_byte = shreg[7:0];
                if (last_byte) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // out_count is only written on the final RUN edge, so it stays put through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            acc       <= '0;
            idx       <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg >> 8;
                    idx   <= idx + IDX_W'(1);
                    if (last_byte) begin
                        out_count <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PARITY_EN
    assign out_parity = out_count[0];
`endif

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed self-checking bench for popcount_seq_ctrl (NBYTES=4) with a count_ones model.
module tb_popcount_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  cu_byte;
    logic [3:0]  cu_ones;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_count;
    logic        busy;
`ifdef PARITY_EN
    logic        out_parity;
`endif

    int assertions = 0;
    int failures   = 0;

    popcount_seq_ctrl #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cu_byte   (cu_byte),
        .cu_ones   (cu_ones),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
`ifdef PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    // Behavioural stand-in for the external count_ones unit.
    assign cu_ones = 4'($countones(cu_byte));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a word for one accept edge, then scramble in_data to show it is not re-sampled.
    task automatic applyStimulus(input logic [31:0] word);
        in_valid = 1'b1;
        in_data  = word;
        tick();
        in_valid = 1'b0;
        in_data  = ~word;
    endtask

    task automatic runWord(input logic [31:0] word, input logic [5:0] exp_count);
        logic [31:0] w;
        w = word;
        applyStimulus(word);
        checkOutput("busy_in_run", {31'b0, busy}, 32'd1);
        checkOutput("in_ready_in_run", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("cu_byte_%0d", i), {24'b0, cu_byte}, {24'b0, w[7:0]});
            checkOutput($sformatf("no_early_valid_%0d", i), {31'b0, out_valid}, 32'd0);
            w = w >> 8;
            tick();
        end
        checkOutput("out_valid_latency", {31'b0, out_valid}, 32'd1);
        checkOutput("out_count", {26'b0, out_count}, {26'b0, exp_count});
        checkOutput("cu_byte_done", {24'b0, cu_byte}, 32'd0);
    endtask

    task automatic consume(input logic [5:0] exp_count);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid_after_consume", {31'b0, out_valid}, 32'd0);
        checkOutput("in_ready_after_consume", {31'b0, in_ready}, 32'd1);
        checkOutput("out_count_retained", {26'b0, out_count}, {26'b0, exp_count});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #2;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_out_count", {26'b0, out_count}, 32'd0);
        checkOutput("reset_cu_byte", {24'b0, cu_byte}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        #10;
        rst = 1'b0;

        $display("[TB] test 1: all zeros");
        runWord(32'h0000_0000, 6'd0);
        consume(6'd0);

        $display("[TB] test 2: all ones");
        runWord(32'hFFFF_FFFF, 6'd32);
        consume(6'd32);

        $display("[TB] test 3: mixed bytes");
        runWord(32'h8100_E626, 6'd10);
        consume(6'd10);

        $display("[TB] test 4: back-pressure in DONE");
        runWord(32'h8100_E626, 6'd10);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("stall_out_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("stall_out_count_%0d", i), {26'b0, out_count}, 32'd10);
            checkOutput($sformatf("stall_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("release_busy_no_accept", {31'b0, busy}, 32'd0);
        checkOutput("release_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("idle_stays_idle", {31'b0, busy}, 32'd0);

        $display("[TB] test 5: reset mid-run");
        applyStimulus(32'hFFFF_FFFF);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_cu_byte", {24'b0, cu_byte}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("abort_no_late_valid", {31'b0, out_valid}, 32'd0);
        runWord(32'h0000_00F0, 6'd4);
        consume(6'd4);

`ifdef PARITY_EN
        $display("[TB] test 6: parity");
        runWord(32'h0000_0007, 6'd3);
        checkOutput("parity_odd", {31'b0, out_parity}, 32'd1);
        consume(6'd3);
        runWord(32'h0000_0003, 6'd2);
        checkOutput("parity_even", {31'b0, out_parity}, 32'd0);
        consume(6'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
